// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: takes one 20-bit command from the AXI slave and runs an I2C
// register write or a register read (with repeated START) on open-drain SCL/SDA.
// The result goes back as an ACK strobe, plus a held read byte for reads.
module i2c_cmd_master #(
  parameter int         CLK_DIV     = 250,
  parameter logic [2:0] DEV_ADDR_HI = 3'b101
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        I2C_MASTER_TRIGGER,
  input  logic [19:0] ADDR_DATA_OUT,
  input  logic        VALID_ADDR_DATA_OUT,
  output logic        VALID_ADDR_DATA_OUT_ACK,
  output logic        VALID_ADDR_DATA_OUT_ACK_VALID,
  output logic [7:0]  RDATA_OUT,
  output logic        RDATA_VALID,
  input  logic        RDATA_VALID_ACK,
  output logic        PENDING_TRANSACTION_WR,
  output logic        PENDING_TRANSACTION_RD,
  output logic        SCL_OE,
  output logic        SDA_OE,
  input  logic        SDA_I
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_WDATA, S_ACK3,
    S_RSTART, S_RADDR, S_ACK4, S_RBYTE, S_MNACK, S_STOP, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [1:0]    qtr, qtr_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [19:0]   cmd_q;
  logic [7:0]    rx_sh, tx_byte;
  logic          nack, sda_s1, sda_sync;
  logic          scl_nx, sda_nx;
  logic          accept, q_end, bit_end, samp, in_ack;

  assign q_end   = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_end = q_end && (qtr == 2'd3);
  assign samp    = q_end && (qtr == 2'd2);
  assign in_ack  = (state == S_ACK1) || (state == S_ACK2) ||
                   (state == S_ACK3) || (state == S_ACK4);
  assign accept  = (state == S_IDLE) && I2C_MASTER_TRIGGER &&
                   VALID_ADDR_DATA_OUT && !RDATA_VALID;

  // FSM state and bit-timing counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      qtr     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      qtr     <= qtr_nx;
      bit_cnt <= bit_nx;
    end
  end

  // Next state: every bus state advances on the last quarter of its bit
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    qtr_nx   = qtr;
    bit_nx   = bit_cnt;
    if (state == S_IDLE) begin
      div_nx = '0;
      qtr_nx = '0;
      bit_nx = '0;
      if (accept) state_nx = S_START;
    end else if (state == S_DONE) begin
      state_nx = S_IDLE;
    end else begin
      div_nx = q_end ? '0 : div_cnt + 1'b1;
      if (q_end) qtr_nx = qtr + 2'd1;
      if (bit_end) begin
        bit_nx = bit_cnt + 3'd1;
        case (state)
          S_START:  state_nx = S_ADDR;
          S_ADDR:   if (bit_cnt == 3'd7) state_nx = S_ACK1;
          S_ACK1:   state_nx = nack ? S_STOP : S_REG;
          S_REG:    if (bit_cnt == 3'd7) state_nx = S_ACK2;
          S_ACK2:   state_nx = nack ? S_STOP : (cmd_q[15] ? S_WDATA : S_RSTART);
          S_WDATA:  if (bit_cnt == 3'd7) state_nx = S_ACK3;
          S_ACK3:   state_nx = S_STOP;
          // bit 0 is a released clock bit so the slave lets go of its ACK,
          // bit 1 is the actual START pattern
          S_RSTART: if (bit_cnt == 3'd1) state_nx = S_RADDR;
          S_RADDR:  if (bit_cnt == 3'd7) state_nx = S_ACK4;
          S_ACK4:   state_nx = nack ? S_STOP : S_RBYTE;
          S_RBYTE:  if (bit_cnt == 3'd7) state_nx = S_MNACK;
          S_MNACK:  state_nx = S_STOP;
          S_STOP:   state_nx = S_DONE;
          default:  state_nx = S_IDLE;
        endcase
        if (state_nx != state) bit_nx = '0;
      end
    end
  end

  // Byte shifted out in the upcoming state
  always_comb begin
    tx_byte = 8'h00;
    case (state_nx)
      S_ADDR:  tx_byte = {DEV_ADDR_HI, cmd_q[19:16], 1'b0};
      S_REG:   tx_byte = {1'b0, cmd_q[14:8]};
      S_WDATA: tx_byte = cmd_q[7:0];
      S_RADDR: tx_byte = {DEV_ADDR_HI, cmd_q[19:16], 1'b1};
      default: tx_byte = 8'h00;
    endcase
  end

  // Pad drive decode from the next state, so SCL/SDA leave a flop glitch-free
  always_comb begin
    scl_nx = 1'b0;
    sda_nx = 1'b0;
    case (state_nx)
      S_START: begin
        scl_nx = (qtr_nx == 2'd3);
        sda_nx = (qtr_nx != 2'd0);
      end
      S_RSTART: begin
        if (bit_nx == 3'd0) begin
          scl_nx = !qtr_nx[1];
        end else begin
          scl_nx = (qtr_nx == 2'd3);
          sda_nx = (qtr_nx != 2'd0);
        end
      end
      S_STOP: begin
        scl_nx = !qtr_nx[1];
        sda_nx = (qtr_nx != 2'd3);
      end
      S_ADDR, S_REG, S_WDATA, S_RADDR: begin
        scl_nx = !qtr_nx[1];
        sda_nx = !tx_byte[3'd7 - bit_nx];
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_RBYTE, S_MNACK: scl_nx = !qtr_nx[1];
      default: ;
    endcase
  end

  // Command latch, SDA sampling, results and handshake outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cmd_q                         <= '0;
      rx_sh                         <= '0;
      nack                          <= 1'b0;
      sda_s1                        <= 1'b1;
      sda_sync                      <= 1'b1;
      SCL_OE                        <= 1'b0;
      SDA_OE                        <= 1'b0;
      PENDING_TRANSACTION_WR        <= 1'b0;
      PENDING_TRANSACTION_RD        <= 1'b0;
      VALID_ADDR_DATA_OUT_ACK       <= 1'b0;
      VALID_ADDR_DATA_OUT_ACK_VALID <= 1'b0;
      RDATA_OUT                     <= '0;
      RDATA_VALID                   <= 1'b0;
    end else begin
      sda_s1   <= SDA_I;
      sda_sync <= sda_s1;
      SCL_OE   <= scl_nx;
      SDA_OE   <= sda_nx;
      if (accept) begin
        cmd_q                  <= ADDR_DATA_OUT;
        nack                   <= 1'b0;
        PENDING_TRANSACTION_WR <= ADDR_DATA_OUT[15];
        PENDING_TRANSACTION_RD <= !ADDR_DATA_OUT[15];
      end
      if (samp && in_ack && sda_sync) nack <= 1'b1;
      if (samp && state == S_RBYTE) rx_sh <= {rx_sh[6:0], sda_sync};
      VALID_ADDR_DATA_OUT_ACK_VALID <= (state_nx == S_DONE);
      if (state_nx == S_DONE) begin
        PENDING_TRANSACTION_WR  <= 1'b0;
        PENDING_TRANSACTION_RD  <= 1'b0;
        VALID_ADDR_DATA_OUT_ACK <= !nack;
        if (!cmd_q[15] && !nack) begin
          RDATA_OUT   <= rx_sh;
          RDATA_VALID <= 1'b1;
        end
      end else if (RDATA_VALID && RDATA_VALID_ACK) begin
        RDATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Directed bench for i2c_cmd_master with a behavioural I2C slave on the bus.
module tb_i2c_cmd_master;
  localparam int CLK_DIV = 4;

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        I2C_MASTER_TRIGGER = 1'b0, VALID_ADDR_DATA_OUT = 1'b0, RDATA_VALID_ACK = 1'b0;
  logic [19:0] ADDR_DATA_OUT = '0;
  logic        VALID_ADDR_DATA_OUT_ACK, VALID_ADDR_DATA_OUT_ACK_VALID, RDATA_VALID;
  logic [7:0]  RDATA_OUT;
  logic        PENDING_TRANSACTION_WR, PENDING_TRANSACTION_RD, SCL_OE, SDA_OE, SDA_I;

  always #5 ACLK = ~ACLK;

  i2c_cmd_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR_HI(3'b101)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .I2C_MASTER_TRIGGER(I2C_MASTER_TRIGGER),
    .ADDR_DATA_OUT(ADDR_DATA_OUT), .VALID_ADDR_DATA_OUT(VALID_ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT_ACK(VALID_ADDR_DATA_OUT_ACK),
    .VALID_ADDR_DATA_OUT_ACK_VALID(VALID_ADDR_DATA_OUT_ACK_VALID),
    .RDATA_OUT(RDATA_OUT), .RDATA_VALID(RDATA_VALID), .RDATA_VALID_ACK(RDATA_VALID_ACK),
    .PENDING_TRANSACTION_WR(PENDING_TRANSACTION_WR),
    .PENDING_TRANSACTION_RD(PENDING_TRANSACTION_RD),
    .SCL_OE(SCL_OE), .SDA_OE(SDA_OE), .SDA_I(SDA_I));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic       pull = 1'b0, pscl = 1'b1, psda = 1'b1, first = 1'b0, mack = 1'b0, drove = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] sh = '0, rd_byte = '0;
  logic [7:0] rx_q[$];
  int         phase = 0, bitn = 0, nack_at = -1;
  int         starts = 0, stops = 0, rises = 0, cyc = 0, last_rise = -1, pmin = 9999, pmax = 0;
  wire        scl_ln = ~SCL_OE;
  wire        sda_ln = ~(SDA_OE | pull);
  assign SDA_I = sda_ln;

  always @(posedge ACLK) cyc <= cyc + 1;

  // slave: receives bytes, ACKs unless told to NACK byte nack_at, returns rd_byte on reads
  always @(posedge ACLK) begin
    if (clr) begin
      phase <= 0; bitn <= 0; pull <= 1'b0; starts <= 0; stops <= 0; rises <= 0;
      last_rise <= -1; pmin <= 9999; pmax <= 0; drove <= 1'b0; mack <= 1'b0;
      rx_q.delete();
    end else begin
      pscl <= scl_ln;
      psda <= sda_ln;
      if (SCL_OE || SDA_OE) drove <= 1'b1;
      if (pscl && scl_ln && psda && !sda_ln) begin
        starts <= starts + 1; phase <= 1; bitn <= 0; first <= 1'b1;
      end else if (pscl && scl_ln && !psda && sda_ln) begin
        stops <= stops + 1; phase <= 0;
      end else if (!pscl && scl_ln) begin
        rises <= rises + 1;
        if (last_rise >= 0) begin
          if (cyc - last_rise < pmin) pmin <= cyc - last_rise;
          if (cyc - last_rise > pmax) pmax <= cyc - last_rise;
        end
        last_rise <= cyc;
        if (phase == 1) begin sh <= {sh[6:0], sda_ln}; bitn <= bitn + 1; end
        else if (phase == 3) bitn <= bitn + 1;
        else if (phase == 4) mack <= sda_ln;
      end else if (pscl && !scl_ln) begin
        case (phase)
          1: if (bitn == 8) begin
               pull <= (int'(rx_q.size()) != nack_at);
               rx_q.push_back(sh);
               phase <= 2;
             end
          2: begin
               pull <= 1'b0; bitn <= 0; first <= 1'b0;
               if (int'(rx_q.size()) - 1 == nack_at) phase <= 0;
               else if (first && sh[0]) begin phase <= 3; pull <= ~rd_byte[7]; end
               else phase <= 1;
             end
          3: if (bitn == 8) begin pull <= 1'b0; phase <= 4; end
             else pull <= ~rd_byte[3'(7 - bitn)];
          4: phase <= 0;
          default: ;
        endcase
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic [3:0] dev;
    logic [6:0] rg;
    logic [7:0] wd;
    int         nack_at;
    logic [7:0] rd;
    logic       exp_ack;
    int         nbytes;
    logic [7:0] b0, b1, b2;
    int         exp_rises;
    int         exp_starts;
    logic       exp_rv;
  } vec_t;
  vec_t vt[7];

  task automatic slave_clear(input int na, input logic [7:0] rd);
    @(negedge ACLK); clr = 1'b1; nack_at = na; rd_byte = rd;
    @(negedge ACLK); clr = 1'b0;
  endtask

  task automatic run_vec(input int i, input bit inject_busy, input bit defer_ack);
    vec_t v;
    int   n;
    bit   pend_ok, held_ok;
    v = vt[i];
    slave_clear(v.nack_at, v.rd);
    I2C_MASTER_TRIGGER = 1'b1;
    ADDR_DATA_OUT = {v.dev, v.wr, v.rg, v.wd};
    VALID_ADDR_DATA_OUT = 1'b1;
    @(negedge ACLK);
    VALID_ADDR_DATA_OUT = 1'b0;
    chk($sformatf("v%0d pend_wr", i), 32'(PENDING_TRANSACTION_WR), 32'(v.wr));
    chk($sformatf("v%0d pend_rd", i), 32'(PENDING_TRANSACTION_RD), 32'(!v.wr));
    n = 0; pend_ok = 1;
    while (VALID_ADDR_DATA_OUT_ACK_VALID !== 1'b1 && n < 3000) begin
      if (PENDING_TRANSACTION_WR !== v.wr || PENDING_TRANSACTION_RD !== !v.wr) pend_ok = 0;
      if (inject_busy && n == 100) begin
        VALID_ADDR_DATA_OUT = 1'b1; I2C_MASTER_TRIGGER = 1'b0; ADDR_DATA_OUT = 20'h50700;
      end
      if (inject_busy && n == 101) VALID_ADDR_DATA_OUT = 1'b0;
      @(negedge ACLK); n++;
    end
    chk($sformatf("v%0d done_in_time", i), 32'(n < 3000), 32'd1);
    chk($sformatf("v%0d pend_held", i), 32'(pend_ok), 32'd1);
    chk($sformatf("v%0d ack", i), 32'(VALID_ADDR_DATA_OUT_ACK), 32'(v.exp_ack));
    chk($sformatf("v%0d pend_drop", i), {30'd0, PENDING_TRANSACTION_WR, PENDING_TRANSACTION_RD}, 32'd0);
    chk($sformatf("v%0d rvalid", i), 32'(RDATA_VALID), 32'(v.exp_rv));
    if (v.exp_rv) chk($sformatf("v%0d rdata", i), 32'(RDATA_OUT), 32'(v.rd));
    @(negedge ACLK);
    chk($sformatf("v%0d ack_valid_1cyc", i), 32'(VALID_ADDR_DATA_OUT_ACK_VALID), 32'd0);
    I2C_MASTER_TRIGGER = 1'b1;
    if (v.exp_rv && !defer_ack) begin
      held_ok = 1;
      repeat (10) begin
        if (RDATA_VALID !== 1'b1) held_ok = 0;
        @(negedge ACLK);
      end
      chk($sformatf("v%0d rvalid_held", i), 32'(held_ok), 32'd1);
      RDATA_VALID_ACK = 1'b1;
      @(negedge ACLK);
      RDATA_VALID_ACK = 1'b0;
      chk($sformatf("v%0d rvalid_clr", i), 32'(RDATA_VALID), 32'd0);
    end
    repeat (4) @(negedge ACLK);
    chk($sformatf("v%0d nbytes", i), 32'(rx_q.size()), 32'(v.nbytes));
    if (rx_q.size() > 0) chk($sformatf("v%0d byte0", i), 32'(rx_q[0]), 32'(v.b0));
    if (rx_q.size() > 1 && v.nbytes > 1) chk($sformatf("v%0d byte1", i), 32'(rx_q[1]), 32'(v.b1));
    if (rx_q.size() > 2 && v.nbytes > 2) chk($sformatf("v%0d byte2", i), 32'(rx_q[2]), 32'(v.b2));
    chk($sformatf("v%0d scl_rises", i), 32'(rises), 32'(v.exp_rises));
    chk($sformatf("v%0d starts", i), 32'(starts), 32'(v.exp_starts));
    chk($sformatf("v%0d stops", i), 32'(stops), 32'd1);
    chk($sformatf("v%0d bus_idle", i), {30'd0, SCL_OE, SDA_OE}, 32'd0);
    if (v.exp_rv) chk($sformatf("v%0d master_nack", i), 32'(mack), 32'd1);
    if (v.wr) begin
      chk($sformatf("v%0d scl_per_min", i), 32'(pmin), 32'(4 * CLK_DIV));
      chk($sformatf("v%0d scl_per_max", i), 32'(pmax), 32'(4 * CLK_DIV));
    end
  endtask

  task automatic all_out_zero(input string name);
    chk(name, {17'd0, SCL_OE, SDA_OE, VALID_ADDR_DATA_OUT_ACK, VALID_ADDR_DATA_OUT_ACK_VALID,
               RDATA_OUT, RDATA_VALID, PENDING_TRANSACTION_WR, PENDING_TRANSACTION_RD}, 32'd0);
  endtask

  initial begin
    bit pend_seen;
    //        wr    dev    reg     wd     nack rd     ack  n  b0     b1     b2    rises st rv
    vt[0] = '{1'b1, 4'h5, 7'h12, 8'hA5, -1, 8'h00, 1'b1, 3, 8'hAA, 8'h12, 8'hA5, 28, 1, 1'b0};
    vt[1] = '{1'b1, 4'h5, 7'h12, 8'hA5,  0, 8'h00, 1'b0, 1, 8'hAA, 8'h00, 8'h00, 10, 1, 1'b0};
    vt[2] = '{1'b0, 4'h5, 7'h07, 8'h00, -1, 8'h3C, 1'b1, 3, 8'hAA, 8'h07, 8'hAB, 38, 2, 1'b1};
    vt[3] = '{1'b1, 4'hC, 7'h7F, 8'h00,  2, 8'h00, 1'b0, 3, 8'hB8, 8'h7F, 8'h00, 28, 1, 1'b0};
    vt[4] = '{1'b0, 4'h0, 7'h33, 8'h00,  1, 8'h00, 1'b0, 2, 8'hA0, 8'h33, 8'h00, 19, 1, 1'b0};
    vt[5] = '{1'b0, 4'h3, 7'h01, 8'h00,  2, 8'hFF, 1'b0, 3, 8'hA6, 8'h01, 8'hA7, 29, 2, 1'b0};
    vt[6] = '{1'b0, 4'hF, 7'h55, 8'h00, -1, 8'h81, 1'b1, 3, 8'hBE, 8'h55, 8'hBF, 38, 2, 1'b1};

    // reset state
    repeat (3) @(negedge ACLK);
    all_out_zero("reset_outputs");
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    // VALID with TRIGGER low is ignored
    slave_clear(-1, 8'h00);
    I2C_MASTER_TRIGGER = 1'b0; ADDR_DATA_OUT = 20'h5_9_2A5; VALID_ADDR_DATA_OUT = 1'b1;
    pend_seen = 0;
    repeat (50) begin
      @(negedge ACLK);
      if (PENDING_TRANSACTION_WR || PENDING_TRANSACTION_RD) pend_seen = 1;
    end
    VALID_ADDR_DATA_OUT = 1'b0;
    chk("trig0_no_pending", 32'(pend_seen), 32'd0);
    chk("trig0_no_bus", 32'(drove), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, 1'b0, 1'b0);

    // second VALID while busy (and TRIGGER dropping) changes nothing
    run_vec(0, 1'b1, 1'b0);

    // VALID while RDATA_VALID is still held is ignored
    run_vec(2, 1'b0, 1'b1);
    slave_clear(-1, 8'h00);
    ADDR_DATA_OUT = 20'h5_9_211; VALID_ADDR_DATA_OUT = 1'b1;
    pend_seen = 0;
    repeat (50) begin
      @(negedge ACLK);
      if (PENDING_TRANSACTION_WR || PENDING_TRANSACTION_RD) pend_seen = 1;
    end
    VALID_ADDR_DATA_OUT = 1'b0;
    chk("rvhold_no_pending", 32'(pend_seen), 32'd0);
    chk("rvhold_no_bus", 32'(drove), 32'd0);
    chk("rvhold_rvalid", 32'(RDATA_VALID), 32'd1);
    chk("rvhold_rdata", 32'(RDATA_OUT), 32'h3C);
    RDATA_VALID_ACK = 1'b1;
    @(negedge ACLK);
    RDATA_VALID_ACK = 1'b0;
    chk("rvhold_clr", 32'(RDATA_VALID), 32'd0);

    // reset in the middle of the register byte
    slave_clear(-1, 8'h00);
    ADDR_DATA_OUT = {4'h5, 1'b1, 7'h12, 8'hA5}; VALID_ADDR_DATA_OUT = 1'b1;
    @(negedge ACLK);
    VALID_ADDR_DATA_OUT = 1'b0;
    repeat (240) @(negedge ACLK);
    chk("midreg_in_reg_byte", 32'(rx_q.size()), 32'd1);
    ARESETn = 1'b0;
    #1;
    all_out_zero("midreg_reset_outputs");
    @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    run_vec(0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
